// File: rtl/image_stream_loader.sv
// image_stream_loader
// Packs a serial pixel stream into one wide frame vector for the first network
// layer. Pixels arrive one word per accepting cycle and are written into slot
// idx (slot 0 at the LSBs). The completed frame is then held, with input
// back-pressured, until downstream acknowledges it.
//
// Handshake: a pixel transfers on a rising edge where pixel_valid and
// pixel_ready are both high. pixel_ready depends on state only, never on
// pixel_valid. pixel_sof only has meaning on a transferring cycle.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   pixel_in      pixel word, stored unchanged
//   pixel_valid   pixel_in is valid this cycle
//   pixel_sof     first pixel of a frame (qualified by pixel_valid)
//   pixel_ready   loader can accept a pixel (high while filling)
//   image         packed frame, pixel i at [i*dataWidth +: dataWidth]
//   image_valid   level, image holds a complete frame
//   frame_done    one-cycle pulse when a frame completes
//   image_ack     downstream captured image; releases the loader
//   frame_err     one-cycle pulse when a partial frame is restarted by SOF
//   dbg_state     FSM state (0 = FILL, 1 = FULL)
//   dbg_idx       current fill index
module image_stream_loader #(
  parameter int weightNo  = 784,
  parameter int dataWidth = 16,
  localparam int IDX_W    = (weightNo > 1) ? $clog2(weightNo) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [dataWidth-1:0]          pixel_in,
  input  logic                          pixel_valid,
  input  logic                          pixel_sof,
  output logic                          pixel_ready,
  output logic [weightNo*dataWidth-1:0] image,
  output logic                          image_valid,
  output logic                          frame_done,
  input  logic                          image_ack,
  output logic                          frame_err,
  output logic                          dbg_state,
  output logic [IDX_W-1:0]              dbg_idx
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(weightNo - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_d, done_d, err_d;
  logic             wr_en;
  logic [IDX_W-1:0] wr_slot;

  assign pixel_ready = (state_q == FILL);
  assign dbg_state   = state_q;
  assign dbg_idx     = idx_q;

  // Next-state and pulse logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = image_valid;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_slot = idx_q;
    case (state_q)
      FILL: begin
        if (pixel_valid) begin
          wr_en   = 1'b1;
          // SOF always lands in slot 0; only a non-empty partial frame is an error.
          wr_slot = pixel_sof ? '0 : idx_q;
          err_d   = pixel_sof && (idx_q != '0);
          if (wr_slot == LAST) begin
            idx_d   = '0;
            state_d = FULL;
            valid_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            idx_d = wr_slot + 1'b1;
          end
        end
      end
      FULL: begin
        if (image_ack) begin
          state_d = FILL;
          valid_d = 1'b0;
          idx_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      image_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      image_valid <= valid_d;
      frame_done  <= done_d;
      frame_err   <= err_d;
    end
  end

  // Slot decoder: only the addressed word is written; the rest hold, which
  // also keeps the frame frozen while FULL and retained after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      image <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < weightNo; i++) begin
        if (wr_slot == IDX_W'(i)) begin
          image[i*dataWidth +: dataWidth] <= pixel_in;
        end
      end
    end
  end

endmodule
